// File: rtl/rel_phase_packer_if.sv
// Phase sample stream in and packed AXI4-Stream word out for rel_phase_packer.
// master is the packer's view; slave is the view of the source/sink environment.
interface rel_phase_packer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                          vld_i;
    logic signed [DATA_WIDTH-1:0]  phase_i;
    logic                          tlast_i;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic [2*DATA_WIDTH-1:0]       m_axis_tdata;
    logic [DATA_WIDTH/4-1:0]       m_axis_tkeep;
    logic                          m_axis_tlast;

    modport master (
        input  vld_i, phase_i, tlast_i, m_axis_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
    );

    modport slave (
        output vld_i, phase_i, tlast_i, m_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
    );
endinterface

// File: rtl/rel_phase_packer.sv
// Packs pairs of phase samples into AXI4-Stream words and buffers them in an FWFT FIFO;
// words that find the FIFO full are dropped and counted.
module rel_phase_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int LW = AW + 1,
    localparam int KW = DATA_WIDTH / 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rel_phase_packer_if.master   bus,
    output logic                 overflow_o,
    output logic [15:0]          drop_cnt_o,
    output logic [LW-1:0]        level_o
);
    typedef struct packed {
        logic [2*DATA_WIDTH-1:0] data;
        logic [KW-1:0]           keep;
        logic                    last;
    } word_t;

    word_t                   mem_q [FIFO_DEPTH];
    logic                    pending_q, pending_d;
    logic [DATA_WIDTH-1:0]   lane_q, lane_d;
    logic [AW-1:0]           wptr_q, rptr_q;
    logic [LW-1:0]           level_q, level_d;
    logic                    overflow_q;
    logic [15:0]             drop_cnt_q;

    word_t                   word;
    word_t                   head;
    logic                    form, rd, wr, drop, nonempty;

    always_comb begin
        pending_d = pending_q;
        lane_d    = lane_q;
        word      = '0;
        form      = bus.vld_i && (pending_q || bus.tlast_i);
        if (pending_q) begin
            word.data = {bus.phase_i, lane_q};
            word.keep = '1;
            word.last = bus.tlast_i;
        end else begin
            word.data = {{DATA_WIDTH{1'b0}}, bus.phase_i};
            word.keep = {{(KW/2){1'b0}}, {(KW/2){1'b1}}};
            word.last = 1'b1;
        end
        if (bus.vld_i) begin
            pending_d = !pending_q && !bus.tlast_i;
            if (!pending_q && !bus.tlast_i)
                lane_d = bus.phase_i;
        end
    end

    // A full FIFO still accepts a word if the head leaves on the same edge.
    assign nonempty = (level_q != '0);
    assign rd       = nonempty && bus.m_axis_tready;
    assign wr       = form && ((level_q != LW'(FIFO_DEPTH)) || rd);
    assign drop     = form && !wr;

    always_comb begin
        level_d = level_q;
        case ({wr, rd})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q  <= 1'b0;
            lane_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            pending_q <= pending_d;
            lane_q    <= lane_d;
            level_q   <= level_d;
            if (wr) wptr_q <= wptr_q + AW'(1);
            if (rd) rptr_q <= rptr_q + AW'(1);
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF)
                    drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && wr)
            mem_q[wptr_q] <= word;
    end

    // Gating by tvalid keeps the bus at zero while empty and out of reset.
    assign head              = mem_q[rptr_q];
    assign bus.m_axis_tvalid = nonempty;
    assign bus.m_axis_tdata  = nonempty ? head.data : '0;
    assign bus.m_axis_tkeep  = nonempty ? head.keep : '0;
    assign bus.m_axis_tlast  = nonempty && head.last;

    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;
    assign level_o    = level_q;
endmodule
